// File: rtl/emu_pkg.sv
// Shared types and default constants for the emulator core controller.
package emu_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } emu_state_e;

  localparam int unsigned EMU_RST_HOLD    = 16;
  localparam logic [7:0]  EMU_CFG_DEFAULT = 8'b0000_1011;

endpackage

// File: rtl/emu_if.sv
// Host-side control/status bundle for emu_ctrl; master drives controls, slave returns status.
interface emu_if #(
  parameter int unsigned CFG_W = 8,
  parameter int unsigned DIV_W = 4,
  parameter int unsigned CNT_W = 32
) ();

  logic             turbo;
  logic [DIV_W-1:0] div;
  logic [CFG_W-1:0] cfg_sw;
  logic             cfg_wr;
  logic             run;
  logic [CNT_W-1:0] cycle_limit;

  logic             core_reset_n;
  logic             core_ce;
  logic [CFG_W-1:0] cfg_sw_q;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       state;
  logic             done;

  modport master (
    output turbo, div, cfg_sw, cfg_wr, run, cycle_limit,
    input  core_reset_n, core_ce, cfg_sw_q, cycles, state, done
  );

  modport slave (
    input  turbo, div, cfg_sw, cfg_wr, run, cycle_limit,
    output core_reset_n, core_ce, cfg_sw_q, cycles, state, done
  );

endinterface

// File: rtl/emu_ce_div.sv
// Clock-enable divider: reload counter, tick on the first cycle after restart.
module emu_ce_div #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic             turbo_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] reload;

  // A ratio of 0 behaves as 1, so the reload value floors at zero.
  assign reload = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign tick_o = turbo_i || (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/emu_ctrl.sv
// Emulated-core controller: reset hold, run/pause, divided clock enable, cycle budget.
// Optional cycle-budget watchdog (HALT / o_done) enabled by defining EMU_WATCHDOG_EN.
module emu_ctrl
  import emu_pkg::*;
#(
  parameter int unsigned      CFG_W       = 8,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(EMU_CFG_DEFAULT),
  parameter int unsigned      RST_HOLD    = EMU_RST_HOLD,
  parameter int unsigned      DIV_W       = 4,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_turbo,
  input  logic [DIV_W-1:0] i_div,
  input  logic [CFG_W-1:0] i_cfg_sw,
  input  logic             i_cfg_wr,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_cycle_limit,
  output logic             o_core_reset_n,
  output logic             o_core_ce,
  output logic [CFG_W-1:0] o_cfg_sw,
  output logic [CNT_W-1:0] o_cycles,
  output logic [1:0]       o_state,
  output logic             o_done
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  emu_state_e       state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CFG_W-1:0] cfg_q;
  logic [CNT_W-1:0] cycles_q;
  logic             done_q;
  logic             core_rst_n_q;

  logic             div_tick;
  logic [CNT_W-1:0] cycles_inc;
  logic             limit_hit;

  emu_ce_div #(.DIV_W(DIV_W)) u_ce_div (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .restart_i (state_q != ST_RUN),
    .turbo_i   (i_turbo),
    .div_i     (i_div),
    .tick_o    (div_tick)
  );

  assign o_core_ce  = (state_q == ST_RUN) && div_tick;
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

`ifdef EMU_WATCHDOG_EN
  assign limit_hit = (i_cycle_limit != '0) && (cycles_inc == i_cycle_limit);
  assign o_done    = done_q;
`else
  logic unused_wdog;
  assign limit_hit   = 1'b0;
  assign o_done      = 1'b0;
  assign unused_wdog = ^{i_cycle_limit, done_q};
`endif

  // Reset beats a config write; a config write beats every FSM transition.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_RESET;
      hold_q       <= HOLD_W'(RST_HOLD);
      cfg_q        <= CFG_DEFAULT;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else if (i_cfg_wr) begin
      state_q      <= ST_RESET;
      hold_q       <= HOLD_W'(RST_HOLD);
      cfg_q        <= i_cfg_sw;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (hold_q <= HOLD_W'(1)) begin
            state_q      <= ST_IDLE;
            core_rst_n_q <= 1'b1;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          if (i_run) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (o_core_ce) begin
            cycles_q <= cycles_inc;
          end
          // Budget exhaustion wins over a simultaneous pause.
          if (o_core_ce && limit_hit) begin
            state_q <= ST_HALT;
            done_q  <= 1'b1;
          end else if (!i_run) begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_RESET;
        end
      endcase
    end
  end

  assign o_core_reset_n = core_rst_n_q;
  assign o_cfg_sw       = cfg_q;
  assign o_cycles       = cycles_q;
  assign o_state        = 2'(state_q);

endmodule

// File: tb/tb_emu_ctrl.sv
// Self-checking bench for emu_ctrl against a cycle-level behavioural model.
// Expectations follow EMU_WATCHDOG_EN exactly as the DUT build does.
module tb_emu_ctrl;

  localparam int unsigned CFG_W = 8;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned CNT_W = 32;
`ifdef EMU_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int S_RESET = 0;
  localparam int S_IDLE  = 1;
  localparam int S_RUN   = 2;
  localparam int S_HALT  = 3;
  localparam longint MAXC = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emu_if #(.CFG_W(CFG_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  emu_ctrl #(
    .CFG_W       (CFG_W),
    .CFG_DEFAULT (8'h0B),
    .RST_HOLD    (16),
    .DIV_W       (DIV_W),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_turbo        (bus.turbo),
    .i_div          (bus.div),
    .i_cfg_sw       (bus.cfg_sw),
    .i_cfg_wr       (bus.cfg_wr),
    .i_run          (bus.run),
    .i_cycle_limit  (bus.cycle_limit),
    .o_core_reset_n (bus.core_reset_n),
    .o_core_ce      (bus.core_ce),
    .o_cfg_sw       (bus.cfg_sw_q),
    .o_cycles       (bus.cycles),
    .o_state        (bus.state),
    .o_done         (bus.done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: state, remaining hold cycles, and divider as "gap since last tick".
  int         m_state;
  int         m_hold;
  logic [7:0] m_cfg;
  longint     m_cycles;
  bit         m_done;
  bit         m_first;
  int         m_gap;
  int         m_ratio;

  int ce_cnt  = 0;
  int rst_low = 0;
  bit last_ce = 1'b0;

  function automatic bit m_tick();
    return bus.turbo || m_first || (m_gap >= m_ratio);
  endfunction

  task automatic model_reset(input logic [7:0] cfg);
    m_state  = S_RESET;
    m_hold   = 16;
    m_cfg    = cfg;
    m_cycles = 0;
    m_done   = 1'b0;
    m_first  = 1'b0;
    m_gap    = 0;
    m_ratio  = 1;
  endtask

  task automatic model_step(input bit ce);
    if (rst) begin
      model_reset(8'h0B);
    end else if (bus.cfg_wr) begin
      model_reset(bus.cfg_sw);
    end else begin
      case (m_state)
        S_RESET: begin
          m_hold--;
          if (m_hold == 0) m_state = S_IDLE;
        end
        S_IDLE: begin
          if (bus.run) begin
            m_state = S_RUN;
            m_first = 1'b1;
          end
        end
        S_RUN: begin
          if (ce) begin
            m_cycles = (m_cycles == MAXC) ? MAXC : m_cycles + 1;
            m_first  = 1'b0;
            m_gap    = 1;
            m_ratio  = (bus.div == 0) ? 1 : int'(bus.div);
          end else begin
            m_gap++;
          end
          if (ce && WDOG && bus.cycle_limit != 0 && m_cycles == longint'(bus.cycle_limit)) begin
            m_state = S_HALT;
            m_done  = 1'b1;
          end else if (!bus.run) begin
            m_state = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc();
    bit ce_exp;
    @(negedge clk);
    ce_exp = (m_state == S_RUN) && m_tick();
    chk("state",   64'(bus.state),        64'(m_state));
    chk("rst_n",   64'(bus.core_reset_n), 64'(m_state != S_RESET));
    chk("ce",      64'(bus.core_ce),      64'(ce_exp));
    chk("cycles",  64'(bus.cycles),       64'(m_cycles));
    chk("done",    64'(bus.done),         64'(m_done));
    chk("cfg",     64'(bus.cfg_sw_q),     64'(m_cfg));
    last_ce = (bus.core_ce === 1'b1);
    if (bus.core_ce === 1'b1) ce_cnt++;
    if (bus.core_reset_n === 1'b0) rst_low++;
    @(posedge clk);
    model_step(ce_exp);
    #1;
  endtask

  task automatic core_reset(input logic [7:0] sw);
    bus.run    = 1'b0;
    bus.cfg_sw = sw;
    bus.cfg_wr = 1'b1;
    cyc();
    bus.cfg_wr = 1'b0;
    repeat (17) cyc();
  endtask

  task automatic hit_cfg(input string tag, input logic [7:0] sw);
    bus.cfg_sw = sw;
    bus.cfg_wr = 1'b1;
    cyc();
    bus.cfg_wr = 1'b0;
    bus.run    = 1'b0;
    chk({tag, "_state"},  64'(bus.state),    64'(S_RESET));
    chk({tag, "_cfg"},    64'(bus.cfg_sw_q), 64'(sw));
    chk({tag, "_cycles"}, 64'(bus.cycles),   64'd0);
    chk({tag, "_done"},   64'(bus.done),     64'd0);
    rst_low = 0;
    repeat (17) cyc();
    chk({tag, "_hold"},   64'(rst_low),      64'd16);
  endtask

  initial begin
    int pos_bad;
    logic [CNT_W-1:0] frozen;

    bus.turbo = 1'b0; bus.div = '0; bus.cfg_sw = '0; bus.cfg_wr = 1'b0;
    bus.run = 1'b0; bus.cycle_limit = '0;
    rst = 1'b1;
    model_reset(8'h0B);

    // Power-on reset and 16-cycle hold
    repeat (3) cyc();
    rst = 1'b0;
    rst_low = 0;
    repeat (20) cyc();
    chk("por_hold",  64'(rst_low),      64'd16);
    chk("por_cfg",   64'(bus.cfg_sw_q), 64'h0B);
    chk("por_state", 64'(bus.state),    64'(S_IDLE));

    // Turbo run against a 100-cycle budget, then config write (HALT when watchdog built)
    bus.turbo = 1'b1; bus.cycle_limit = 100; bus.run = 1'b1;
    ce_cnt = 0;
    repeat (110) cyc();
    chk("lim_ce",     64'(ce_cnt),     WDOG ? 64'd100 : 64'd109);
    chk("lim_cycles", 64'(bus.cycles), WDOG ? 64'd100 : 64'd109);
    chk("lim_done",   64'(bus.done),   64'(WDOG));
    chk("lim_state",  64'(bus.state),  WDOG ? 64'(S_HALT) : 64'(S_RUN));
    hit_cfg("cfg_halt", 8'hA5);

    // Divide by 4: tick in the first RUN cycle and every 4th after
    bus.cycle_limit = 0; bus.turbo = 1'b0; bus.div = 4'd4; bus.run = 1'b1;
    cyc();
    ce_cnt = 0; pos_bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i == 0) chk("div_first", 64'(last_ce), 64'd1);
      if (last_ce && (i % 4) != 0) pos_bad++;
    end
    chk("div4_pos",    64'(pos_bad),    64'd0);
    chk("div4_ce",     64'(ce_cnt),     64'd10);
    chk("div4_cycles", 64'(bus.cycles), 64'd10);
    hit_cfg("cfg_run", 8'hA5);

    // Divide ratio 0 acts as 1
    bus.div = 4'd0; bus.run = 1'b1;
    cyc();
    ce_cnt = 0;
    repeat (40) cyc();
    chk("div0_ce",     64'(ce_cnt),     64'd40);
    chk("div0_cycles", 64'(bus.cycles), 64'd40);
    core_reset(8'h0B);

    // Pause mid-run with a 20-cycle budget
    bus.turbo = 1'b1; bus.cycle_limit = 20; bus.run = 1'b1;
    cyc();
    ce_cnt = 0;
    repeat (10) cyc();
    bus.run = 1'b0;
    cyc();
    frozen = bus.cycles;
    repeat (4) begin
      cyc();
      chk("pause_frz", 64'(bus.cycles), 64'(frozen));
    end
    bus.run = 1'b1;
    repeat (30) cyc();
    chk("pause_ce",   64'(ce_cnt),   WDOG ? 64'd20 : 64'd40);
    chk("pause_done", 64'(bus.done), 64'(WDOG));
    core_reset(8'h0B);

    // Small budget of 5: halts only in a watchdog build
    bus.cycle_limit = 5; bus.run = 1'b1;
    repeat (21) cyc();
    chk("lim5_done",   64'(bus.done),   64'(WDOG));
    chk("lim5_cycles", 64'(bus.cycles), WDOG ? 64'd5 : 64'd20);

    // Randomized traffic, model checks every cycle
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      bus.cfg_wr = ($urandom_range(0, 59) == 0);
      bus.cfg_sw = CFG_W'($urandom);
      if ($urandom_range(0, 3) == 0) bus.run = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) bus.turbo = ~bus.turbo;
      if ($urandom_range(0, 7) == 0) bus.div = DIV_W'($urandom);
      if ($urandom_range(0, 49) == 0) bus.cycle_limit = CNT_W'($urandom_range(0, 40));
      cyc();
    end
    rst = 1'b0; bus.cfg_wr = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/emu_ctrl.md
EMU_CTRL -- requirements
Module: emu_ctrl

Interface
REQ-001 SHALL have parameter CFG_W, default 8, width of the configuration-switch word.
REQ-002 SHALL have parameter CFG_DEFAULT, default 8'b0000_1011, switch word applied after reset.
REQ-003 SHALL have parameter RST_HOLD, default 16, number of cycles core reset is held (minimum 1).
REQ-004 SHALL have parameter DIV_W, default 4, width of the non-turbo divide ratio.
REQ-005 SHALL have parameter CNT_W, default 32, width of the cycle counter and limit.
REQ-006 SHALL have port i_clk  in  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port i_turbo  in  1  1 = core clock enable every cycle; 0 = divided.
REQ-009 SHALL have port i_div  in  DIV_W  divide ratio when i_turbo=0; 0 treated as 1.
REQ-010 SHALL have port i_cfg_sw  in  CFG_W  new switch word.
REQ-011 SHALL have port i_cfg_wr  in  1  one-cycle strobe: latch i_cfg_sw and re-reset the core.
REQ-012 SHALL have port i_run  in  1  level; run enable.
REQ-013 SHALL have port i_cycle_limit  in  CNT_W  enabled-cycle budget; 0 = unlimited.
REQ-014 SHALL have port o_core_reset_n  out  1  active-low reset to the emulated core.
REQ-015 SHALL have port o_core_ce  out  1  core clock enable.
REQ-016 SHALL have port o_cfg_sw  out  CFG_W  registered switch word to the core.
REQ-017 SHALL have port o_cycles  out  CNT_W  count of o_core_ce pulses since last core reset.
REQ-018 SHALL have port o_state  out  2  FSM state encoding.
REQ-019 SHALL have port o_done  out  1  cycle budget exhausted.

Function
REQ-020 SHALL implement the FSM states RESET=0, IDLE=1, RUN=2, HALT=3, and SHALL drive o_state with that encoding.
REQ-021 In RESET, the block SHALL hold o_core_reset_n=0 and o_core_ce=0 for exactly RST_HOLD cycles, then enter IDLE.
REQ-022 In IDLE, o_core_reset_n SHALL be 1 and o_core_ce 0, and i_run=1 SHALL move the FSM to RUN on the next edge.
REQ-023 In RUN, i_run=0 SHALL move the FSM to IDLE on the next edge (pause), with o_cycles held.
REQ-024 o_core_ce SHALL be combinational: (state==RUN) AND div_tick.
REQ-025 div_tick SHALL be 1 every cycle when i_turbo=1, and otherwise 1 once per max(i_div,1) cycles.
REQ-026 The divider SHALL restart on entry to RUN so that the first RUN cycle carries a tick.
REQ-027 o_cycles SHALL increment on every cycle with o_core_ce=1, SHALL saturate at all-ones, and SHALL clear on entering RESET.
REQ-028 When i_cycle_limit!=0 and the increment makes o_cycles equal i_cycle_limit, the FSM SHALL enter HALT on that same edge, giving exactly i_cycle_limit ce pulses.
REQ-029 In HALT, o_done SHALL be 1, o_core_ce 0 and o_core_reset_n 1, and i_run SHALL be ignored.
REQ-030 i_cfg_wr=1 in any state SHALL latch i_cfg_sw into o_cfg_sw, clear o_done, and enter RESET on the next edge; it overrides all other transitions.
REQ-031 A change of i_turbo or i_div during RUN SHALL take effect at the next divider reload.

Reset
REQ-032 i_reset=1 SHALL set state=RESET, o_core_reset_n=0, o_core_ce=0, o_cfg_sw=CFG_DEFAULT, o_cycles=0, o_done=0, and the hold counter to RST_HOLD.
REQ-033 i_reset SHALL take priority over i_cfg_wr, and the RST_HOLD count SHALL start on the first cycle with i_reset=0.

Configuration
REQ-034 With macro EMU_WATCHDOG_EN defined, the block SHALL perform the limit compare of REQ-028 and use HALT/o_done.
REQ-035 With EMU_WATCHDOG_EN undefined, the block SHALL ignore i_cycle_limit, HALT SHALL be unreachable, and o_done SHALL be tied 0; the ports SHALL be unchanged.

Structure
REQ-036 The state enum and the default RST_HOLD and CFG_DEFAULT constants SHALL reside in package emu_pkg.
REQ-037 The clock-enable divider (reload counter, restart input, tick output) SHALL be sub-module emu_ce_div.

Verification
REQ-038 The bench SHALL cover: i_reset high 3 cycles then low -> o_core_reset_n=0 for exactly 16 cycles, o_cfg_sw=8'h0B, o_state=IDLE.
REQ-039 The bench SHALL cover: i_turbo=1, i_run=1, i_cycle_limit=100 -> 100 consecutive ce pulses, o_cycles=100, o_done=1, o_state=HALT.
REQ-040 The bench SHALL cover: i_turbo=0, i_div=4, run 40 cycles -> ce every 4th cycle, first in the first RUN cycle, o_cycles=10; the same with i_div=0 -> ce every cycle.
REQ-041 The bench SHALL cover: i_run dropped for 5 cycles mid-run with limit 20 -> o_cycles frozen while low, total ce pulses still 20.
REQ-042 The bench SHALL cover: i_cfg_wr with i_cfg_sw=8'hA5 during RUN and during HALT -> next cycle RESET, o_cfg_sw=8'hA5, o_cycles=0, o_done=0, then 16-cycle reset hold.
REQ-043 The bench SHALL cover: a build without EMU_WATCHDOG_EN and i_cycle_limit=5 -> run continues past 5, o_done stays 0.
